// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: op encodings, FSM states and cycle defaults.
// Imported by the MDU, the hazard unit and the controller.
package mdu_hilo_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int CNT_W           = 16;

   function automatic logic is_mul(mdu_op_t op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div(mdu_op_t op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the MDU.
// The pipeline is the master; the MDU is the slave.
interface mdu_hilo_if;
   import mdu_hilo_pkg::*;

   logic        start;
   mdu_op_t     op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, op, A, B,
      input  busy, HI, LO
   );

   modport slave (
      input  start, op, A, B,
      output busy, HI, LO
   );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 32-bit signed/unsigned multiply and divide.
// Division works on magnitudes so the INT_MIN / -1 case cannot overflow.
module mdu_arith
   import mdu_hilo_pkg::*;
(
   input  mdu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   logic        sgn;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] dvs;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        neg_q;
   logic        neg_r;

   assign sgn = (op == MDU_MULT) || (op == MDU_DIV);

   // Low 64 bits of the extended product are correct for both signednesses
   assign ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
   assign ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
   assign prod  = ext_a * ext_b;

   assign mag_a = (sgn && a[31]) ? (~a + 32'd1) : a;
   assign mag_b = (sgn && b[31]) ? (~b + 32'd1) : b;

   assign div_zero = is_div(op) && (b == 32'd0);
   assign dvs      = (b == 32'd0) ? 32'd1 : mag_b;
   assign quo      = mag_a / dvs;
   assign rem      = mag_a % dvs;
   assign neg_q    = sgn && (a[31] ^ b[31]);
   assign neg_r    = sgn && a[31];

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      unique case (1'b1)
         is_mul(op): begin
            hi = prod[63:32];
            lo = prod[31:0];
         end
         is_div(op): begin
            hi = neg_r ? (~rem + 32'd1) : rem;
            lo = neg_q ? (~quo + 32'd1) : quo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MDU with architectural HI/LO, beside the ALU in E.
// Results are captured at start and committed only when busy ends.
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   mdu_hilo_if.slave   bus
);

   localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

   mdu_state_t       state_q;
   mdu_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_wr;

   logic             load;
   logic             commit;
   logic             wr_hi;
   logic             wr_lo;

   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_dz;

   mdu_arith u_arith (
      .op       (bus.op),
      .a        (bus.A),
      .b        (bus.B),
      .hi       (res_hi),
      .lo       (res_lo),
      .div_zero (res_dz)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      commit  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               unique case (1'b1)
                  is_mul(bus.op): begin
                     load    = 1'b1;
                     cnt_d   = MUL_N;
                     state_d = ST_BUSY;
                  end
                  is_div(bus.op): begin
                     load    = 1'b1;
                     cnt_d   = DIV_N;
                     state_d = ST_BUSY;
                  end
                  (bus.op == MDU_MTHI): wr_hi = 1'b1;
                  (bus.op == MDU_MTLO): wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            // Starts here are stalled upstream, so they are simply ignored
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_BUSY);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else if (load) begin
         pend_hi <= res_hi;
         pend_lo <= res_lo;
         pend_wr <= !res_dz;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (commit && pend_wr) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
         end
         if (wr_hi) hi_q <= bus.A;
         if (wr_lo) lo_q <= bus.A;
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed cases plus a randomized run against
// a plain-arithmetic HI/LO model.
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;
   localparam int LIMIT = 40;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_hilo_if bus ();

   mdu_hilo #(
      .MULT_CYCLES (NM),
      .DIV_CYCLES  (ND)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural reference: signed/unsigned 64-bit arithmetic.
   function automatic void model(input mdu_op_t op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint r64;
      longint q64;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         MDU_MULT: begin
            r64 = sa * sb;
            m_hi = r64[63:32];
            m_lo = r64[31:0];
         end
         MDU_MULTU: begin
            r64 = ua * ub;
            m_hi = r64[63:32];
            m_lo = r64[31:0];
         end
         MDU_DIV: if (b != 0) begin
            q64 = sa / sb;
            r64 = sa % sb;
            m_hi = r64[31:0];
            m_lo = q64[31:0];
         end
         MDU_DIVU: if (b != 0) begin
            q64 = ua / ub;
            r64 = ua % ub;
            m_hi = r64[31:0];
            m_lo = q64[31:0];
         end
         MDU_MTHI: m_hi = a;
         MDU_MTLO: m_lo = a;
         default: ;
      endcase
   endfunction

   // Drive one start pulse; returns #1 after the sampling edge.
   task automatic issue(input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = MDU_NONE;
   endtask

   // Count busy cycles (bounded); flag any HI/LO movement while busy.
   task automatic count_busy(output int n, output logic moved);
      logic [31:0] h0;
      logic [31:0] l0;
      h0 = bus.HI;
      l0 = bus.LO;
      n = 0;
      moved = 1'b0;
      while (bus.busy === 1'b1 && n < LIMIT) begin
         n++;
         if (bus.HI !== h0 || bus.LO !== l0) moved = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.start = 1'b0;
      bus.op = MDU_NONE;
      bus.A = '0;
      bus.B = '0;
      m_hi = '0;
      m_lo = '0;
      #3;
      checks++;
      if (bus.busy !== 1'b0 || bus.HI !== 0 || bus.LO !== 0) begin
         failures++;
         $display("FAIL reset_state busy=%b HI=%h LO=%h want 0/0/0",
                  bus.busy, bus.HI, bus.LO);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mult();
      int n;
      logic mv;
      issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
      model(MDU_MULT, 32'hFFFFFFFE, 32'd3);
      count_busy(n, mv);
      checks++;
      if (n != NM || mv) begin
         failures++;
         $display("FAIL mult_busy cycles=%0d moved=%b want %0d/0", n, mv, NM);
      end
      checks++;
      if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFA) begin
         failures++;
         $display("FAIL mult_res HI=%h LO=%h want ffffffff/fffffffa",
                  bus.HI, bus.LO);
      end
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      model(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      count_busy(n, mv);
      checks++;
      if (n != NM || bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h1) begin
         failures++;
         $display("FAIL multu cycles=%0d HI=%h LO=%h want %0d/fffffffe/1",
                  n, bus.HI, bus.LO, NM);
      end
   endtask

   task automatic test_div();
      int n;
      logic mv;
      issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
      model(MDU_DIV, 32'hFFFFFFF9, 32'd2);
      count_busy(n, mv);
      checks++;
      if (n != ND || mv) begin
         failures++;
         $display("FAIL div_busy cycles=%0d moved=%b want %0d/0", n, mv, ND);
      end
      checks++;
      if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
         failures++;
         $display("FAIL div_res HI=%h LO=%h want ffffffff/fffffffd",
                  bus.HI, bus.LO);
      end
      issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2);
      model(MDU_DIVU, 32'hFFFFFFF9, 32'd2);
      count_busy(n, mv);
      checks++;
      if (bus.HI !== 32'h1 || bus.LO !== 32'h7FFFFFFC) begin
         failures++;
         $display("FAIL divu_res HI=%h LO=%h want 1/7ffffffc",
                  bus.HI, bus.LO);
      end
      issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      model(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      count_busy(n, mv);
      checks++;
      if (bus.HI !== 32'h0 || bus.LO !== 32'h80000000) begin
         failures++;
         $display("FAIL div_ovf HI=%h LO=%h want 0/80000000",
                  bus.HI, bus.LO);
      end
   endtask

   task automatic test_mt_divzero();
      int n;
      logic mv;
      bus.start = 1'b1;
      bus.op = MDU_MTHI;
      bus.A = 32'h12345678;
      @(posedge clk);
      #1;
      model(MDU_MTHI, 32'h12345678, 32'd0);
      checks++;
      if (bus.HI !== 32'h12345678 || bus.LO !== m_lo || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mthi HI=%h LO=%h busy=%b want 12345678/%h/0",
                  bus.HI, bus.LO, bus.busy, m_lo);
      end
      bus.op = MDU_MTLO;
      bus.A = 32'h9ABCDEF0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = MDU_NONE;
      model(MDU_MTLO, 32'h9ABCDEF0, 32'd0);
      checks++;
      if (bus.HI !== 32'h12345678 || bus.LO !== 32'h9ABCDEF0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mtlo HI=%h LO=%h busy=%b want 12345678/9abcdef0/0",
                  bus.HI, bus.LO, bus.busy);
      end
      issue(MDU_DIV, 32'h55555555, 32'd0);
      count_busy(n, mv);
      checks++;
      if (n != ND || bus.HI !== 32'h12345678 || bus.LO !== 32'h9ABCDEF0) begin
         failures++;
         $display("FAIL div_zero cycles=%0d HI=%h LO=%h want %0d/12345678/9abcdef0",
                  n, bus.HI, bus.LO, ND);
      end
   endtask

   task automatic test_noop();
      logic [31:0] h0;
      logic [31:0] l0;
      h0 = bus.HI;
      l0 = bus.LO;
      issue(MDU_NONE, 32'hDEADBEEF, 32'd1);
      issue(MDU_RSVD, 32'hCAFEF00D, 32'd1);
      checks++;
      if (bus.busy !== 1'b0 || bus.HI !== h0 || bus.LO !== l0) begin
         failures++;
         $display("FAIL noop busy=%b HI=%h LO=%h want 0/%h/%h",
                  bus.busy, bus.HI, bus.LO, h0, l0);
      end
   endtask

   task automatic test_ignore_busy();
      int n;
      logic mv;
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom_range(1, 1000);
      issue(MDU_DIV, a, b);
      model(MDU_DIV, a, b);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.A = $urandom;
      bus.B = $urandom;
      bus.start = 1'b1;
      bus.op = MDU_MULT;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = MDU_NONE;
      count_busy(n, mv);
      checks++;
      if (n + 3 != ND || bus.HI !== m_hi || bus.LO !== m_lo) begin
         failures++;
         $display("FAIL ignore_busy cycles=%0d HI=%h LO=%h want %0d/%h/%h",
                  n + 3, bus.HI, bus.LO, ND, m_hi, m_lo);
      end
   endtask

   task automatic test_async_reset();
      int bad;
      issue(MDU_MTHI, 32'hA5A5A5A5, 32'd0);
      issue(MDU_MTLO, 32'h5A5A5A5A, 32'd0);
      issue(MDU_DIV, 32'd1000, 32'd7);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      checks++;
      if (bus.busy !== 1'b0 || bus.HI !== 0 || bus.LO !== 0) begin
         failures++;
         $display("FAIL async_reset busy=%b HI=%h LO=%h want 0/0/0",
                  bus.busy, bus.HI, bus.LO);
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < ND + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b0 || bus.HI !== 0 || bus.LO !== 0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL late_commit bad_cycles=%0d want 0", bad);
      end
   endtask

   task automatic test_random();
      int n;
      logic mv;
      mdu_op_t op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 30; i++) begin
         op = mdu_op_t'($urandom_range(1, 6));
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
         if (i == 7) begin
            op = MDU_DIV;
            a = 32'h80000000;
            b = 32'hFFFFFFFF;
         end
         issue(op, a, b);
         model(op, a, b);
         count_busy(n, mv);
         checks++;
         if (n != (is_mul(op) ? NM : is_div(op) ? ND : 0) || mv ||
             bus.HI !== m_hi || bus.LO !== m_lo) begin
            failures++;
            $display("FAIL rand[%0d] op=%0d a=%h b=%h cyc=%0d mv=%b HI=%h LO=%h want %h/%h",
                     i, op, a, b, n, mv, bus.HI, bus.LO, m_hi, m_lo);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_mult();
      test_div();
      test_mt_divzero();
      test_noop();
      test_ignore_busy();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the E stage. It is the producer side of the general register file write data for MFHI/MFLO.
- It exposes busy so the hazard unit can stall D-stage MDU instructions.
- HI/LO are read combinationally by the E stage. The value flows down the pipeline to the GRF write port.

Parameters:
MULT_CYCLES, 5, E-stage cycles busy stays high after a MULT/MULTU start (>=1)
DIV_CYCLES, 10, E-stage cycles busy stays high after a DIV/DIVU start (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  E-stage MDU instruction valid this cycle
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
busy  output  1  multi-cycle operation in progress
HI  output  32  current HI register
LO  output  32  current LO register

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, counter=0, busy=0, HI=0, LO=0, pending result registers=0.
  - Reset mid-operation aborts it; no result is ever written.
- States: IDLE, BUSY. busy is a registered output, high exactly in BUSY.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}, sampled at edge k:
  - Compute the result from A/B at edge k and store it in pending registers. Later operand changes are ignored.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Go to BUSY.
- BUSY:
  - Decrement counter each edge.
  - At the edge where counter==1: commit pending to HI/LO and go to IDLE.
  - With N = cycle parameter, busy is high for cycles k+1..k+N. HI/LO change at edge k+N. busy=0 from k+N.
- MTHI/MTLO in IDLE: HI<=A (or LO<=A) at the same edge. busy stays 0. The other register is unchanged.
- Any start while BUSY is ignored; the hazard unit guarantees a stall. Assertion: start && busy && op!=NONE never occurs.
- start with op NONE/7: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=prod[63:32], LO=prod[31:0].
  - MULTU: same, unsigned.
  - DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - DIVU: unsigned quotient and remainder.
- Boundaries:
  - Divisor B==0: the operation still runs the full DIV_CYCLES with busy high, but HI/LO are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Results are registered only at commit. HI/LO outputs never show partial values.
- No internal forwarding of in-flight results: MFHI/MFLO must stall while busy (hazard-unit rule: stall if D-stage is MDU-class and (busy || start)).

Decomposition:
- Shared package: op encodings MDU_NONE..MDU_MTLO (3-bit), and default cycle constants.
- The hazard unit and controller reuse the same op constants.
- One natural sub-module: mdu_arith, a combinational 32-bit signed/unsigned multiply/divide producing {hi,lo} and a div_zero flag.
- mdu_hilo holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE(-2) B=3 -> busy 1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 in consecutive cycles -> busy stays 0; HI/LO updated at each edge. Then DIV by B=0 -> busy 10 cycles, HI/LO keep those values.
- Start DIV, change A/B and pulse start with MULT during BUSY -> result reflects the original DIV only; MULT is ignored.
- Start DIV, drive reset=0 asynchronously at cycle 4 -> busy, HI and LO go to 0 immediately without waiting for a clock edge. After release, IDLE with no late commit.
